chacha_qr_engine: RTL

//  Sequential ChaCha quarter-round engine, parametrised in word width, rotation amounts and round count.

---
 rtl/chacha_pkg.sv | 31 +++
 rtl/chacha_arx_step.sv | 26 ++
 rtl/chacha_qr_engine.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha quarter-round engine.
//   qr_state_e    : engine FSM states (idle / running ARX steps / result held)
//   ROTn_DEFAULT  : the standard ChaCha rotation amounts 16/12/8/7
//   rotl()        : rotate-left of a word held in the low `width` bits of a
//                   64-bit container; bits above `width` are returned as zero.
package chacha_pkg;

  typedef enum logic [1:0] {
    QR_IDLE = 2'd0,
    QR_RUN  = 2'd1,
    QR_DONE = 2'd2
  } qr_state_e;

  localparam int ROT0_DEFAULT = 16;
  localparam int ROT1_DEFAULT = 12;
  localparam int ROT2_DEFAULT = 8;
  localparam int ROT3_DEFAULT = 7;

  // Width is a run-time argument so one helper serves every legal WORD_W.
  // amount must satisfy 0 < amount < width.
  function automatic logic [63:0] rotl(input logic [63:0] word,
                                       input logic [6:0]  amount,
                                       input logic [6:0]  width = 7'd64);
    logic [63:0] mask;
    logic [6:0]  back;
    mask = (width >= 7'd64) ? '1 : ((64'd1 << width) - 64'd1);
    back = width - amount;
    return ((word << amount) | (word >> back)) & mask;
  endfunction

endpackage

// File: rtl/chacha_arx_step.sv
// One ChaCha ARX step: x_new = x + y; z_new = rotl(z ^ x_new, r).
// Purely combinational; all arithmetic modulo 2^WORD_W.
// Ports:
//   x, y, z : operand words
//   r       : rotate-left amount (0 < r < WORD_W)
//   x_new   : updated x
//   z_new   : updated z
module chacha_arx_step
  import chacha_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  logic [WORD_W-1:0] z,
  input  logic [6:0]        r,
  output logic [WORD_W-1:0] x_new,
  output logic [WORD_W-1:0] z_new
);

  always_comb begin
    x_new = x + y;
    z_new = WORD_W'(rotl(64'(z ^ x_new), r, 7'(WORD_W)));
  end

endmodule

// File: rtl/chacha_qr_engine.sv
// Sequential ChaCha quarter-round engine: accepts a {d,c,b,a} state over a
// valid/ready handshake, performs one ARX step per clock (4 per quarter
// round, ROUNDS quarter rounds per job) and holds the result until taken.
// Optional build macro: CHACHA_FEEDFORWARD_EN -- the accepted input is kept in
// a copy register and added word-wise to the final state on the outputs.
// Ports:
//   clk, rst             : clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  : input handshake; in_ready only while idle
//   in_state             : {d,c,b,a}, a in the LSBs
//   out_valid / out_ready: result handshake; out_valid only while done
//   out_state            : {d,c,b,a} result
//   addr_in / data_out   : byte read port; addr_in = {word, byte}, combinational
module chacha_qr_engine
  import chacha_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 1,
  parameter int ROT0   = ROT0_DEFAULT,
  parameter int ROT1   = ROT1_DEFAULT,
  parameter int ROT2   = ROT2_DEFAULT,
  parameter int ROT3   = ROT3_DEFAULT,
  localparam int ADDR_W = 2 + $clog2(WORD_W / 8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*WORD_W-1:0]   in_state,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*WORD_W-1:0]   out_state,
  input  logic [ADDR_W-1:0]     addr_in,
  output logic [7:0]            data_out
);

  localparam int RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(ROUNDS - 1);

  if (!(WORD_W == 8 || WORD_W == 16 || WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
    $error("chacha_qr_engine: WORD_W must be 8, 16, 32 or 64");
  end
  if (ROUNDS < 1) begin : g_bad_rounds
    $error("chacha_qr_engine: ROUNDS must be at least 1");
  end
  if (ROT0 <= 0 || ROT0 >= WORD_W || ROT1 <= 0 || ROT1 >= WORD_W ||
      ROT2 <= 0 || ROT2 >= WORD_W || ROT3 <= 0 || ROT3 >= WORD_W) begin : g_bad_rot
    $error("chacha_qr_engine: rotation amounts must lie in 1..WORD_W-1");
  end

  qr_state_e         state;
  logic [1:0]        step;
  logic [RND_W-1:0]  round;
  logic [WORD_W-1:0] a, b, c, d;
`ifdef CHACHA_FEEDFORWARD_EN
  logic [4*WORD_W-1:0] in_copy;
`endif

  // Even steps update (a, d) from b; odd steps update (c, b) from d.
  logic [WORD_W-1:0] x_sel, y_sel, z_sel, x_new, z_new;
  logic [6:0]        rot_sel;

  always_comb begin
    x_sel   = step[0] ? c : a;
    y_sel   = step[0] ? d : b;
    z_sel   = step[0] ? b : d;
    rot_sel = 7'(ROT3);
    case (step)
      2'd0:    rot_sel = 7'(ROT0);
      2'd1:    rot_sel = 7'(ROT1);
      2'd2:    rot_sel = 7'(ROT2);
      default: rot_sel = 7'(ROT3);
    endcase
  end

  chacha_arx_step #(.WORD_W(WORD_W)) u_arx (
    .x     (x_sel),
    .y     (y_sel),
    .z     (z_sel),
    .r     (rot_sel),
    .x_new (x_new),
    .z_new (z_new)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= QR_IDLE;
      step      <= 2'd0;
      round     <= '0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      d         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifdef CHACHA_FEEDFORWARD_EN
      in_copy   <= '0;
`endif
    end else begin
      case (state)
        QR_IDLE: begin
          if (in_valid) begin
            a        <= in_state[0*WORD_W +: WORD_W];
            b        <= in_state[1*WORD_W +: WORD_W];
            c        <= in_state[2*WORD_W +: WORD_W];
            d        <= in_state[3*WORD_W +: WORD_W];
`ifdef CHACHA_FEEDFORWARD_EN
            in_copy  <= in_state;
`endif
            step     <= 2'd0;
            round    <= '0;
            in_ready <= 1'b0;
            state    <= QR_RUN;
          end
        end
        QR_RUN: begin
          if (step[0]) begin
            c <= x_new;
            b <= z_new;
          end else begin
            a <= x_new;
            d <= z_new;
          end
          step <= step + 2'd1;
          if (step == 2'd3) begin
            if (round == LAST_ROUND) begin
              round     <= '0;
              out_valid <= 1'b1;
              state     <= QR_DONE;
            end else begin
              round <= round + RND_W'(1);
            end
          end
        end
        QR_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= QR_IDLE;
          end
        end
        default: begin
          state     <= QR_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef CHACHA_FEEDFORWARD_EN
  always_comb begin
    out_state[0*WORD_W +: WORD_W] = a + in_copy[0*WORD_W +: WORD_W];
    out_state[1*WORD_W +: WORD_W] = b + in_copy[1*WORD_W +: WORD_W];
    out_state[2*WORD_W +: WORD_W] = c + in_copy[2*WORD_W +: WORD_W];
    out_state[3*WORD_W +: WORD_W] = d + in_copy[3*WORD_W +: WORD_W];
  end
`else
  assign out_state = {d, c, b, a};
`endif

  // Word field above byte field makes addr_in the flat byte index of out_state.
  assign data_out = out_state[{addr_in, 3'b000} +: 8];

endmodule
